// File: rtl/fetch_prefetch_q_if.sv
// fetch_prefetch_q_if: fetch/consume bus for the prefetch queue; master drives control and im data, slave is the queue
interface fetch_prefetch_q_if #(parameter int DEPTH = 4, parameter int AW = 16, parameter int DW = 32);
  logic                    redirect;
  logic [AW-1:0]           redirect_addr;
  logic [AW-1:0]           im_addr;
  logic [DW-1:0]           im_data;
  logic                    pop;
  logic [DW-1:0]           instr;
  logic [AW-1:0]           instr_pc;
  logic                    valid;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  modport master (
    output redirect, redirect_addr, im_data, pop,
    input  im_addr, instr, instr_pc, valid, full, count
  );
  modport slave (
    input  redirect, redirect_addr, im_data, pop,
    output im_addr, instr, instr_pc, valid, full, count
  );
endinterface

// File: rtl/fetch_prefetch_q.sv
// fetch_prefetch_q: instruction prefetch FIFO between imem and IR, redirectable fetch pointer.
// Define PREFETCH_HALT_STOP_EN to stop fetching after an HLT word (im_data[31:28]==4'hF) is queued.
module fetch_prefetch_q #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst_f,
  fetch_prefetch_q_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] fptr;
  logic [PW-1:0] head, tail;
  logic [PW:0]   cnt;
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic          is_valid, is_full, pop_eff, push, stall;
  assign is_valid = cnt != '0;
  assign is_full  = cnt == (PW+1)'(DEPTH);
  assign pop_eff  = q.pop && is_valid;
  assign push     = !q.redirect && !stall && (!is_full || pop_eff);
`ifdef PREFETCH_HALT_STOP_EN
  logic halted;
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) halted <= 1'b0;
    else if (q.redirect) halted <= 1'b0;
    else if (push && q.im_data[DW-1 -: 4] == 4'hF) halted <= 1'b1;
  assign stall = halted;
`else
  assign stall = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) begin
      fptr <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.redirect) begin
      fptr <= q.redirect_addr;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
        fptr <= fptr + AW'(1);
      end
      if (pop_eff) head <= head + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop_eff);
    end
  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[tail]   <= fptr;
      data_mem[tail] <= q.im_data;
    end
  assign q.im_addr  = fptr;
  assign q.valid    = is_valid;
  assign q.full     = is_full;
  assign q.count    = cnt;
  assign q.instr    = is_valid ? data_mem[head] : '0;
  assign q.instr_pc = is_valid ? pc_mem[head] : '0;
endmodule

// File: tb/tb_fetch_prefetch_q.sv
// tb_fetch_prefetch_q: scoreboard bench for the prefetch queue, imem modelled as addr+0x1000 with an optional HLT word
module tb_fetch_prefetch_q;
  localparam int DEPTH = 4, AW = 16, DW = 32;
  logic clk = 1'b0, rst_f = 1'b0;
  logic hlt_en = 1'b0;
  logic [AW-1:0] hlt_addr = '0;
  int n_run = 0, n_fail = 0;
  logic [AW+DW-1:0] sb[$];
  logic [AW-1:0] m_fptr = '0;
  logic m_halt = 1'b0;
  fetch_prefetch_q_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) q();
  fetch_prefetch_q #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_f(rst_f), .q(q));
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] imem(input logic [AW-1:0] a, input logic en, input logic [AW-1:0] h);
    return (en && a == h) ? {4'hF, 12'h000, a} : {16'h0000, a} + 32'h1000;
  endfunction
  always_comb q.im_data = imem(q.im_addr, hlt_en, hlt_addr);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    logic [AW+DW-1:0] hd;
    hd = sb.size() != 0 ? sb[0] : '0;
    chk("valid", 64'(q.valid), 64'(sb.size() != 0));
    chk("count", 64'(q.count), 64'(sb.size()));
    chk("full", 64'(q.full), 64'(sb.size() == DEPTH));
    chk("im_addr", 64'(q.im_addr), 64'(m_fptr));
    chk("instr_pc", 64'(q.instr_pc), 64'(hd[AW+DW-1:DW]));
    chk("instr", 64'(q.instr), 64'(hd[DW-1:0]));
  endtask
  task automatic step(input logic p, input logic r, input logic [AW-1:0] ra);
    logic [DW-1:0] d;
    logic pe, ps;
    check_all();
    q.pop = p;
    q.redirect = r;
    q.redirect_addr = ra;
    @(posedge clk);
    if (r) begin
      sb.delete();
      m_fptr = ra;
      m_halt = 1'b0;
    end else begin
      pe = p && sb.size() != 0;
      ps = !m_halt && (sb.size() < DEPTH || pe);
      if (pe) void'(sb.pop_front());
      if (ps) begin
        d = imem(m_fptr, hlt_en, hlt_addr);
        sb.push_back({m_fptr, d});
`ifdef PREFETCH_HALT_STOP_EN
        if (d[31:28] == 4'hF) m_halt = 1'b1;
`endif
        m_fptr++;
      end
    end
    @(negedge clk);
  endtask
  task automatic async_reset();
    #($urandom_range(1, 4));
    rst_f = 1'b0;
    #1;
    chk("rst_valid", 64'(q.valid), 64'd0);
    chk("rst_full", 64'(q.full), 64'd0);
    chk("rst_count", 64'(q.count), 64'd0);
    chk("rst_instr", 64'(q.instr), 64'd0);
    chk("rst_instr_pc", 64'(q.instr_pc), 64'd0);
    chk("rst_im_addr", 64'(q.im_addr), 64'd0);
    sb.delete();
    m_fptr = '0;
    m_halt = 1'b0;
    q.pop = 1'b0;
    q.redirect = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
  endtask
  initial begin
    q.pop = 1'b0;
    q.redirect = 1'b0;
    q.redirect_addr = '0;
    async_reset();
    step(1'b1, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, '0);
    chk("t1_im_addr", 64'(q.im_addr), 64'd4);
    chk("t1_count", 64'(q.count), 64'd4);
    repeat (6) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 16'h0100);
    repeat (3) step(1'b0, 1'b0, '0);
    chk("t3_count", 64'(q.count), 64'd3);
    step(1'b1, 1'b1, 16'h0040);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 16'hFFFE);
    repeat (6) step(1'b0, 1'b0, '0);
    repeat (5) step(1'b1, 1'b0, '0);
    async_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    async_reset();
    hlt_en = 1'b1;
    hlt_addr = 16'd2;
    repeat (6) step(1'b0, 1'b0, '0);
`ifdef PREFETCH_HALT_STOP_EN
    chk("t6_im_addr", 64'(q.im_addr), 64'd3);
    chk("t6_count", 64'(q.count), 64'd3);
`else
    chk("t6_im_addr", 64'(q.im_addr), 64'd4);
    chk("t6_count", 64'(q.count), 64'd4);
`endif
    step(1'b0, 1'b1, 16'h0010);
    repeat (4) step(1'b1, 1'b0, '0);
    check_all();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
